// File: rtl/snake_pkg.sv
// Shared snake-game types: coordinate widths, playfield limits and the target placer state encoding.
package snake_pkg;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int MAX_X_DEF = 159;
    localparam int MAX_Y_DEF = 119;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_BOUNDS,
        ST_SCAN,
        ST_ARMED
    } placer_state_t;
endpackage

// File: rtl/target_placer_if.sv
// Target placer bus: generator request/candidate, head stream, body memory port and published target.
interface target_placer_if #(
    parameter int ADDR_W  = 5,
    parameter int SCORE_W = 8
) ();
    import snake_pkg::*;

    logic               START;
    logic [X_W-1:0]     HEAD_X;
    logic [Y_W-1:0]     HEAD_Y;
    logic               HEAD_VALID;
    logic [X_W-1:0]     RAND_X;
    logic [Y_W-1:0]     RAND_Y;
    logic               REACHED_TARGET;
    logic [ADDR_W:0]    SNAKE_LEN;
    logic [ADDR_W-1:0]  BODY_RD_ADDR;
    logic [X_W-1:0]     BODY_X;
    logic [Y_W-1:0]     BODY_Y;
    logic [X_W-1:0]     TARGET_X;
    logic [Y_W-1:0]     TARGET_Y;
    logic               TARGET_VALID;
    logic               EAT;
    logic [SCORE_W-1:0] SCORE;
    logic               PLACE_FAIL;

    modport master (
        input  START, HEAD_X, HEAD_Y, HEAD_VALID, RAND_X, RAND_Y,
               SNAKE_LEN, BODY_X, BODY_Y,
        output REACHED_TARGET, BODY_RD_ADDR, TARGET_X, TARGET_Y,
               TARGET_VALID, EAT, SCORE, PLACE_FAIL
    );

    modport slave (
        output START, HEAD_X, HEAD_Y, HEAD_VALID, RAND_X, RAND_Y,
               SNAKE_LEN, BODY_X, BODY_Y,
        input  REACHED_TARGET, BODY_RD_ADDR, TARGET_X, TARGET_Y,
               TARGET_VALID, EAT, SCORE, PLACE_FAIL
    );
endinterface

// File: rtl/target_placer_body_scan.sv
// Walks body memory 0..len-1 and compares each returned segment with the candidate.
// Address is registered; data for index i is compared one cycle after i is presented.
module body_scan
    import snake_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              en,
    input  logic [ADDR_W:0]   snake_len,
    input  logic [X_W-1:0]    body_x,
    input  logic [Y_W-1:0]    body_y,
    input  logic [X_W-1:0]    cand_x,
    input  logic [Y_W-1:0]    cand_y,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              match,
    output logic              done
);
    logic            pres;
    logic            cmp_vld;
    logic            last_d;
    logic [ADDR_W:0] last_idx;
    logic            at_last;

    assign last_idx = snake_len - 1'b1;
    assign at_last  = ({1'b0, rd_addr} == last_idx);

    always_ff @(posedge CLK) begin
        if (RESET || start) begin
            rd_addr <= '0;
            pres    <= start && !RESET;
            cmp_vld <= 1'b0;
            last_d  <= 1'b0;
        end else if (en) begin
            cmp_vld <= pres;
            last_d  <= pres && at_last;
            if (pres) begin
                if (at_last) pres    <= 1'b0;
                else         rd_addr <= rd_addr + 1'b1;
            end
        end else begin
            pres    <= 1'b0;
            cmp_vld <= 1'b0;
            last_d  <= 1'b0;
        end
    end

    assign match = cmp_vld && (body_x == cand_x) && (body_y == cand_y);
    assign done  = cmp_vld && last_d && !match;
endmodule

// File: rtl/target_placer.sv
// Requests, settles, validates and publishes snake targets; counts eats. START->TARGET_VALID 6 cycles best case.
// Body-overlap rejection (SCAN state) is compiled in only with TARGET_BODY_CHECK_EN.
module target_placer
    import snake_pkg::*;
#(
    parameter int MAX_X     = MAX_X_DEF,
    parameter int MAX_Y     = MAX_Y_DEF,
    parameter int ADDR_W    = 5,
    parameter int SCORE_W   = 8,
    parameter int MAX_RETRY = 15,
    parameter int SETTLE    = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    target_placer_if.master bus
);
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [X_W-1:0]     LIM_X     = X_W'(MAX_X);
    localparam logic [Y_W-1:0]     LIM_Y     = Y_W'(MAX_Y);
    localparam logic [X_W-1:0]     FB_X      = X_W'(MAX_X / 2);
    localparam logic [Y_W-1:0]     FB_Y      = Y_W'(MAX_Y / 2);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    placer_state_t  state, state_nxt;
    logic [CW-1:0]  settle_cnt;
    logic [RW-1:0]  retry;
    logic [X_W-1:0] cand_x;
    logic [Y_W-1:0] cand_y;
    logic           settle_last, cand_bad, scan_need, scan_match, scan_done;
    logic           reject, exhaust, arm, eat_hit;

    assign settle_last = (state == ST_SETTLE) && (settle_cnt == CW'(SETTLE - 1));
    assign cand_bad = (cand_x == '0) || (cand_x > LIM_X) ||
                      (cand_y == '0) || (cand_y > LIM_Y) ||
                      ((cand_x == bus.HEAD_X) && (cand_y == bus.HEAD_Y));
    assign eat_hit  = (state == ST_ARMED) && bus.HEAD_VALID &&
                      (bus.HEAD_X == bus.TARGET_X) && (bus.HEAD_Y == bus.TARGET_Y);

`ifdef TARGET_BODY_CHECK_EN
    logic scan_start;
    assign scan_need  = (bus.SNAKE_LEN != '0);
    assign scan_start = (state == ST_BOUNDS) && !cand_bad && scan_need;

    body_scan #(.ADDR_W(ADDR_W)) u_body_scan (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (scan_start),
        .en        (state == ST_SCAN),
        .snake_len (bus.SNAKE_LEN),
        .body_x    (bus.BODY_X),
        .body_y    (bus.BODY_Y),
        .cand_x    (cand_x),
        .cand_y    (cand_y),
        .rd_addr   (bus.BODY_RD_ADDR),
        .match     (scan_match),
        .done      (scan_done)
    );
`else
    logic unused_body;
    assign unused_body      = ^{bus.BODY_X, bus.BODY_Y, bus.SNAKE_LEN};
    assign scan_need        = 1'b0;
    assign scan_match       = 1'b0;
    assign scan_done        = 1'b0;
    assign bus.BODY_RD_ADDR = {ADDR_W{1'b0}};
`endif

    always_comb begin
        state_nxt = state;
        reject    = 1'b0;
        arm       = 1'b0;
        exhaust   = 1'b0;
        case (state)
            ST_IDLE:   if (bus.START) state_nxt = ST_REQ;
            ST_REQ:    state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_last) state_nxt = ST_BOUNDS;
            ST_BOUNDS: begin
                if (cand_bad)       reject    = 1'b1;
                else if (scan_need) state_nxt = ST_SCAN;
                else                arm       = 1'b1;
            end
            ST_SCAN: begin
                if (scan_match)     reject = 1'b1;
                else if (scan_done) arm    = 1'b1;
            end
            ST_ARMED:  if (eat_hit) state_nxt = ST_REQ;
            default:   state_nxt = ST_IDLE;
        endcase
        // The reject that would reach MAX_RETRY publishes the fallback instead of retrying.
        exhaust = reject && (retry == RW'(MAX_RETRY - 1));
        if (reject)   state_nxt = exhaust ? ST_ARMED : ST_REQ;
        if (arm)      state_nxt = ST_ARMED;
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            settle_cnt       <= '0;
            retry            <= '0;
            cand_x           <= '0;
            cand_y           <= '0;
            bus.TARGET_X     <= '0;
            bus.TARGET_Y     <= '0;
            bus.TARGET_VALID <= 1'b0;
            bus.SCORE        <= '0;
            bus.PLACE_FAIL   <= 1'b0;
        end else begin
            bus.PLACE_FAIL <= 1'b0;
            if (state == ST_REQ)         settle_cnt <= '0;
            else if (state == ST_SETTLE) settle_cnt <= settle_cnt + 1'b1;
            if (settle_last) begin
                cand_x <= bus.RAND_X;
                cand_y <= bus.RAND_Y;
            end
            if (exhaust) begin
                bus.TARGET_X     <= FB_X;
                bus.TARGET_Y     <= FB_Y;
                bus.TARGET_VALID <= 1'b1;
                bus.PLACE_FAIL   <= 1'b1;
                retry            <= '0;
            end else if (arm) begin
                bus.TARGET_X     <= cand_x;
                bus.TARGET_Y     <= cand_y;
                bus.TARGET_VALID <= 1'b1;
                retry            <= '0;
            end else if (reject) begin
                retry <= retry + 1'b1;
            end
            if (eat_hit) begin
                bus.TARGET_VALID <= 1'b0;
                if (bus.SCORE != SCORE_MAX) bus.SCORE <= bus.SCORE + 1'b1;
            end
        end
    end

    // Gated with RESET so a request never leaks out during the reset cycle.
    assign bus.REACHED_TARGET = (state == ST_REQ) && !RESET;
    assign bus.EAT            = eat_hit && !RESET;
endmodule

// File: tb/tb_target_placer.sv
// Table-driven bench for target_placer with a generator model, body memory model and target scoreboard.
module tb_target_placer;
    import snake_pkg::*;

    typedef struct {
        int         pre;
        int         nc;
        logic [7:0] x0, x1, x2;
        logic [6:0] y0, y1, y2;
        logic [7:0] hx;
        logic [6:0] hy;
        logic [7:0] ex;
        logic [6:0] ey;
        int         ereq;
        logic       efail;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic       fail;
    } exp_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    target_placer_if #(.ADDR_W(5), .SCORE_W(8)) bus ();

    target_placer #(
        .MAX_X(159), .MAX_Y(119), .ADDR_W(5), .SCORE_W(8), .MAX_RETRY(15), .SETTLE(3)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Generator model: each request pulse loads the next candidate of the current sequence.
    int         req_cnt = 0;
    int         base    = 0;
    int         g_pre   = 0;
    int         g_nc    = 0;
    int         gk, gi;
    logic [7:0] g_x [3];
    logic [6:0] g_y [3];

    always @(negedge CLK) begin
        if (bus.REACHED_TARGET === 1'b1) begin
            gk = req_cnt - base;
            if (g_nc == 0 || gk < g_pre) begin
                bus.RAND_X = 8'd0;
                bus.RAND_Y = 7'd0;
            end else begin
                gi = gk - g_pre;
                if (gi > g_nc - 1) gi = g_nc - 1;
                bus.RAND_X = g_x[gi];
                bus.RAND_Y = g_y[gi];
            end
            req_cnt = req_cnt + 1;
        end
    end

    logic [7:0] mem_x [32];
    logic [6:0] mem_y [32];

    always @(posedge CLK) begin
        bus.BODY_X <= mem_x[bus.BODY_RD_ADDR];
        bus.BODY_Y <= mem_y[bus.BODY_RD_ADDR];
    end

    exp_t exp_q[$];
    vec_t vecs [9];

    function automatic vec_t mk(int pre, int nc,
                                logic [7:0] x0, logic [6:0] y0, logic [7:0] x1, logic [6:0] y1,
                                logic [7:0] x2, logic [6:0] y2, logic [7:0] hx, logic [6:0] hy,
                                logic [7:0] ex, logic [6:0] ey, int ereq, logic efail);
        vec_t v;
        v.pre = pre; v.nc = nc;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
        v.hx = hx; v.hy = hy; v.ex = ex; v.ey = ey; v.ereq = ereq; v.efail = efail;
        return v;
    endfunction

    function automatic logic [31:0] outs();
        return {bus.REACHED_TARGET, bus.TARGET_X, bus.TARGET_Y, bus.TARGET_VALID,
                bus.EAT, bus.SCORE, bus.PLACE_FAIL, bus.BODY_RD_ADDR};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        else             n_pass++;
    endtask

    task automatic wait_armed(output int cyc);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= 400 && !seen; c++) begin
            tick();
            cyc = c;
            if (bus.TARGET_VALID === 1'b1) seen = 1'b1;
        end
        check("armed_in_time", seen, 1);
        check("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (seen) begin
                check("target_x", bus.TARGET_X, e.x);
                check("target_y", bus.TARGET_Y, e.y);
                check("place_fail", bus.PLACE_FAIL, e.fail);
            end
        end
    endtask

    task automatic load_gen(input vec_t v);
        g_pre  = v.pre;
        g_nc   = v.nc;
        g_x[0] = v.x0; g_y[0] = v.y0;
        g_x[1] = v.x1; g_y[1] = v.y1;
        g_x[2] = v.x2; g_y[2] = v.y2;
        base   = req_cnt;
    endtask

    task automatic run_vec(input vec_t v, input bit chk_lat);
        int cyc;
        bus.HEAD_X = v.hx;
        bus.HEAD_Y = v.hy;
        load_gen(v);
        RESET = 1'b1;
        tick();
        check("reset_outs", outs(), 0);
        RESET = 1'b0;
        exp_q.push_back('{x: v.ex, y: v.ey, fail: v.efail});
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("start_to_req", bus.REACHED_TARGET, 1);
        wait_armed(cyc);
        if (chk_lat) check("start_to_valid_cycles", cyc + 1, 6);
        check("req_count", req_cnt - base, v.ereq);
        tick();
        check("fail_pulse_len", {bus.PLACE_FAIL, bus.TARGET_VALID}, 2'b01);
    endtask

    initial begin
        int cyc;
        int exp_score;
        bit found;

        vecs[0] = mk(0,  1,  50, 20,   0,  0,  0,  0,  1,  1,  50, 20,  1, 0);
        vecs[1] = mk(0,  3,   0, 20, 170, 20, 40, 30,  1,  1,  40, 30,  3, 0);
        vecs[2] = mk(0,  0,   0,  0,   0,  0,  0,  0,  1,  1,  79, 59, 15, 1);
        vecs[3] = mk(0,  2,  30, 40,  30, 41,  0,  0, 30, 40,  30, 41,  2, 0);
        vecs[4] = mk(0,  1, 159,119,   0,  0,  0,  0,  1,  1, 159,119,  1, 0);
        vecs[5] = mk(0,  3, 160,  5,   5,120,  1,  1,  2,  2,   1,  1,  3, 0);
        vecs[6] = mk(14, 1,  10, 10,   0,  0,  0,  0,  1,  1,  10, 10, 15, 0);
        vecs[7] = mk(0,  2, 159,  0,   2,  2,  0,  0,  5,  5,   2,  2,  2, 0);
        vecs[8] = mk(0,  1,  60, 60,   0,  0,  0,  0,  1,  1,  60, 60,  1, 0);

        for (int i = 0; i < 32; i++) begin
            mem_x[i] = 8'(100 + i);
            mem_y[i] = 7'(90 + i);
        end
        mem_x[2] = 8'd40;
        mem_y[2] = 7'd30;

        bus.START      = 1'b0;
        bus.HEAD_X     = 8'd1;
        bus.HEAD_Y     = 7'd1;
        bus.HEAD_VALID = 1'b0;
        bus.SNAKE_LEN  = 6'd0;
        RESET          = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i == 0);

`ifdef TARGET_BODY_CHECK_EN
        bus.SNAKE_LEN = 6'd4;
        run_vec(mk(0, 2, 40, 30, 60, 60, 0, 0, 1, 1, 60, 60, 2, 0), 0);
        load_gen(mk(0, 1, 70, 70, 0, 0, 0, 0, 1, 1, 70, 70, 1, 0));
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            tick();
            if (bus.BODY_RD_ADDR === 5'd2) found = 1'b1;
        end
        check("scan_reached_idx2", found, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid_scan_reset_outs", outs(), 0);
        bus.SNAKE_LEN = 6'd0;
`endif

        run_vec(vecs[8], 0);

        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("start_ignored_armed", {bus.REACHED_TARGET, bus.TARGET_VALID}, 2'b01);

        bus.HEAD_X = 8'd60; bus.HEAD_Y = 7'd61; bus.HEAD_VALID = 1'b1;
        #1;
        check("eat_wrong_pos", bus.EAT, 0);
        tick();
        bus.HEAD_Y = 7'd60; bus.HEAD_VALID = 1'b0;
        #1;
        check("eat_without_valid", bus.EAT, 0);
        tick();

        exp_score = 0;
        for (int i = 1; i <= 256; i++) begin
            bus.HEAD_X = 8'd60; bus.HEAD_Y = 7'd60; bus.HEAD_VALID = 1'b1;
            #1;
            exp_score = (exp_score == 255) ? 255 : exp_score + 1;
            if (i <= 2 || i >= 255) check("eat_pulse", bus.EAT, 1);
            if (i < 256) exp_q.push_back('{x: 8'd60, y: 7'd60, fail: 1'b0});
            tick();
            bus.HEAD_VALID = 1'b0; bus.HEAD_X = 8'd1; bus.HEAD_Y = 7'd1;
            if (i <= 2 || i >= 255) begin
                check("score", bus.SCORE, exp_score);
                check("eat_len", bus.EAT, 0);
                check("eat_to_req", bus.REACHED_TARGET, 1);
                check("valid_drop", bus.TARGET_VALID, 0);
            end
            if (i < 256) wait_armed(cyc);
        end

        RESET = 1'b1;
        #1;
        check("no_req_in_reset", bus.REACHED_TARGET, 0);
        tick();
        RESET = 1'b0;
        check("mid_run_reset_outs", outs(), 0);
        bus.HEAD_X = 8'd60; bus.HEAD_Y = 7'd60; bus.HEAD_VALID = 1'b1;
        #1;
        check("no_eat_after_reset", bus.EAT, 0);
        tick();
        bus.HEAD_VALID = 1'b0;
        tick();
        check("idle_after_reset", outs(), 0);

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
